// File: rtl/poisson_pkg.sv
// Shared constants and helpers for the multi-channel Poisson spike source.
package poisson_pkg;
  localparam logic [15:0] TAP_MASK    = 16'hB400;
  localparam logic [15:0] SEED_STRIDE = 16'h9E37;

  // Channels get decorrelated seeds; an all-zero seed would lock the LFSR, so map it to 1.
  function automatic logic [15:0] seed_for(input logic [15:0] base, input int idx);
    logic [31:0] prod;
    logic [15:0] s;
    prod = 32'(idx) * 32'(SEED_STRIDE);
    s = base ^ prod[15:0];
    return (s == 16'h0) ? 16'h0001 : s;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < 16; k++) c = c + 5'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/lfsr16_en.sv
// 16-bit right-shifting Galois LFSR that advances only on enabled ticks.
module lfsr16_en
  import poisson_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] rnd
);
  always_ff @(posedge clk) begin
    if (rst)     rnd <= SEED;
    else if (en) rnd <= (rnd >> 1) ^ (rnd[0] ? TAP_MASK : 16'h0000);
  end
endmodule

// File: rtl/poisson_spike_array.sv
// N_CH independent Poisson spike channels with programmable rate and refractory period.
module poisson_spike_array
  import poisson_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter logic [15:0] RATE_DEF = 16'd3277,
  parameter int          REFRAC_W = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_ch,
  input  logic [15:0]                cfg_rate,
  input  logic [REFRAC_W-1:0]        cfg_refrac,
  output logic [N_CH-1:0]            spike,
  output logic [$clog2(N_CH+1)-1:0]  spike_pop
);
  localparam int PW = $clog2(N_CH + 1);

  logic [N_CH-1:0][15:0]         rnd;
  logic [N_CH-1:0][15:0]         rate;
  logic [N_CH-1:0][REFRAC_W-1:0] refrac;
  logic [N_CH-1:0][REFRAC_W-1:0] rcnt;
  logic [N_CH-1:0]               fire;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lfsr16_en #(.SEED(seed_for(SEED, i))) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .rnd (rnd[i])
    );
    assign fire[i] = en && (rcnt[i] == '0) && (rnd[i] < rate[i]);
  end

  // Fire and rcnt reload see pre-write rate/refrac; writes land at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike     <= '0;
      spike_pop <= '0;
      rate      <= {N_CH{RATE_DEF}};
      refrac    <= '0;
      rcnt      <= '0;
    end else begin
      spike     <= fire;
      spike_pop <= PW'(popcount16(16'(fire)));
      for (int i = 0; i < N_CH; i++) begin
        if (en) begin
          if (fire[i])             rcnt[i] <= refrac[i];
          else if (rcnt[i] != '0)  rcnt[i] <= rcnt[i] - 1'b1;
        end
        if (cfg_we && (cfg_ch == 4'(i))) begin
          rate[i]   <= cfg_rate;
          refrac[i] <= cfg_refrac;
        end
      end
    end
  end
endmodule

// File: doc/poisson_spike_array.md
# poisson_spike_array

Multi-channel Poisson spike source for driving LIF neuron inputs. It generalises the single-channel fixed-rate generator into N_CH independent channels. Each channel has its own 16-bit Galois LFSR, a runtime-programmable firing rate, and an absolute refractory period. A global enable gates all activity. A registered popcount reports how many channels fired each cycle.

## Interface
Parameters:
- N_CH, 4: number of independent spike channels (1..16)
- RATE_DEF, 16'd3277: reset rate for every channel; fires with probability RATE/65536 per tick (≈5%)
- REFRAC_W, 4: width of the per-channel refractory period register
- SEED, 16'hACE1: base LFSR seed

Ports:
- clk  in  1: clock
- rst  in  1: synchronous, active-high reset
- en  in  1: global tick enable
- cfg_we  in  1: configuration write strobe
- cfg_ch  in  4: channel index for the write
- cfg_rate  in  16: rate value to write
- cfg_refrac  in  REFRAC_W: refractory period to write, in enabled ticks
- spike  out  N_CH: per-channel one-cycle spike pulses, registered
- spike_pop  out  $clog2(N_CH+1): number of bits set in spike, registered alongside it

## Operation
- **Reset.**
  - spike=0, spike_pop=0.
  - rate[i]=RATE_DEF, refrac[i]=0, rcnt[i]=0.
  - lfsr[i] = SEED ^ (i*16'h9E37), truncated to 16 bits. If that result is 0, use 16'h0001.
- **LFSR.**
  - Galois, right shift, tap mask 16'hB400: next = (r>>1) ^ (r[0] ? 16'hB400 : 0).
  - Advances only in cycles with en=1. It never reaches 0.
- **Fire decision per channel**, evaluated in cycle t: fire[i] = en && rcnt[i]==0 && lfsr[i] < rate[i].
  - The comparison is unsigned and uses the current (pre-advance) LFSR value.
  - rate=0 never fires.
  - rate=16'hFFFF fires unless the LFSR value equals 16'hFFFF.
- **Refractory counter rcnt[i]**, updated when en=1:
  - If fire[i]: rcnt[i] ← refrac[i].
  - Else if rcnt[i]≠0: rcnt[i] ← rcnt[i]−1.
  - When en=0, rcnt holds.
  - With refrac=k, the next spike on that channel comes at least k+1 enabled ticks later.
- **Configuration.**
  - When cfg_we=1 and cfg_ch<N_CH, rate[cfg_ch] and refrac[cfg_ch] are written at the clock edge.
  - When cfg_ch≥N_CH, the write is ignored.
  - Configuration writes are accepted regardless of en.
- **Simultaneous write and fire on the same channel.** The fire decision and the rcnt load both use the pre-write rate and refrac values.
- **Disabling.** en=0 forces spike=0 and spike_pop=0 on the next edge. All LFSR and refractory state freezes.
- **Reset mid-operation.** Reset wins over everything, including cfg_we, and restores full reset state.

## Timing
- spike[i] and spike_pop are both registered from fire at edge t+1. Latency is 1 cycle from the LFSR value to the pulse.
- Each pulse is exactly one cycle wide per fire event.
- A channel fires on back-to-back cycles only if refrac=0.
- A config write sampled at edge t affects fire decisions from cycle t+1, so the earliest spike using the new rate appears at edge t+2.
- The first enabled cycle after reset compares the seed values. The first possible spike is at the edge after en rises.
- spike_pop equals the popcount of spike in the same cycle, always.

## Structure
- Package poisson_pkg holds:
  - TAP_MASK=16'hB400
  - SEED_STRIDE=16'h9E37
  - the seed-derivation function (including the zero guard)
  - the popcount function
- Sub-module lfsr16_en: one 16-bit Galois LFSR with clk, rst, en, a SEED parameter and a rnd output. Instantiate it N_CH times in a generate loop.
- Keep the rate, refrac and rcnt storage in the top level as arrays.

## Test plan
- **Reset values.** After reset with N_CH=4, confirm spike=0, spike_pop=0, and lfsr[0]=16'hACE1. Confirm lfsr[1]=16'hACE1^16'h9E37=16'h32D6.
- **Rate extremes.** Write rate 0 to ch0 and 16'hFFFF to ch1 with refrac 0, then run 10000 enabled cycles. Expect ch0 never to spike and ch1 to spike on at least 9990 cycles. Expect ch2 at the default rate to fire 500±90 times.
- **Refractory.** Write ch1 refrac=3 with rate=16'hFFFF. Expect every gap between ch1 spikes to be at least 4 cycles, with gaps of exactly 4 dominating.
- **Enable gating.** Drop en for 20 cycles mid-run. Expect spike=0 from the next edge, and the LFSR and rcnt values to match their pre-drop values when en returns.
- **Write timing.** Write rate=16'hFFFF to ch3 (default refrac 0) at edge t. Expect no change at edge t+1 caused by the write, and spike[3]=1 at edge t+2. Also write with cfg_ch=7 and confirm no channel changes.
- **Reset mid-run.** Assert rst while spikes are active and cfg_we=1. Expect all outputs to be 0 after the edge, the ignored write to leave no trace, and the LFSR sequence to restart identically.
